regfile_arbiter: RTL and testbench
==================================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter ARB_MODE, default 1, arbitration policy: 0 = fixed priority (port 0 wins), 1 = round-robin.
REQ-002 Parameter STARVE_LIMIT, default 4, lost-arbitration cycles after which port 1 is force-granted in ARB_MODE 0; range 1..15.
REQ-003 I_clk  in  1  single clock; all state updates on rising edge.
REQ-004 I_reset_n  in  1  asynchronous, active-low reset.
REQ-005 I_req  in  2  per-port request; bit0 = CPU pipeline, bit1 = debug port.
REQ-006 I_we  in  2  per-port write enable; 0 = read-only access.
REQ-007 I_rA_sel0, I_rB_sel0, I_rD_sel0, I_rA_sel1, I_rB_sel1, I_rD_sel1  in  3 each  per-port register selects.
REQ-008 I_wdata0, I_wdata1  in  16 each  per-port write data.
REQ-009 I_wpos0, I_wpos1  in  2 each  write position: 0 = full word, 1 = low byte, 2 = high byte, 3 = illegal.
REQ-010 O_gnt  out  2  one-hot grant pulse, one cycle.
REQ-011 O_rvalid  out  2  one-hot read-data-valid pulse, one cycle.
REQ-012 O_rA_data, O_rB_data  out  16 each  read data to the granted port.
REQ-013 O_err  out  2  one-cycle pulse, granted access carried wpos = 3.
REQ-014 O_rf_reset  out  1  synchronous active-high reset to register file.
REQ-015 O_rf_enable, O_rf_write  out  1 each  register file enable and write strobe.
REQ-016 O_rf_rA_sel, O_rf_rB_sel, O_rf_rD_sel  out  3 each; O_rf_wdata  out  16; O_rf_wpos  out  2.
REQ-017 I_rf_rA_out, I_rf_rB_out  in  16 each  register file registered read outputs.

Function
REQ-018 FSM states INIT, IDLE, ISSUE, RESP; one access in flight at a time.
REQ-019 INIT: O_rf_reset = 1 for exactly one cycle, then IDLE unconditionally.
REQ-020 IDLE: if any I_req bit set, arbitrate, latch winner's selects, we, wdata, wpos into command registers, go ISSUE; else stay.
REQ-021 ISSUE: O_gnt[winner] = 1, O_rf_enable = 1, O_rf_* = latched command, O_rf_write = latched we AND wpos != 3; go RESP.
REQ-022 wpos = 3 in ISSUE: O_rf_write = 0, O_err[winner] = 1; reads still performed.
REQ-023 RESP: O_rvalid[winner] = 1; O_rA_data/O_rB_data = I_rf_rA_out/I_rf_rB_out; go IDLE.
REQ-024 Latency: request sampled at edge k -> O_gnt high cycle k+1 -> O_rvalid high cycle k+2; peak throughput one access per 3 cycles.
REQ-025 Read of a register written by the same access returns the pre-write value.
REQ-026 Requester holds I_req and payload stable until its O_gnt; deassertion before grant withdraws the request without side effect.
REQ-027 Round-robin: pointer = last granted port; on contention the other port wins; single requester always wins.
REQ-028 Fixed priority: port 0 wins contention unless starve counter = STARVE_LIMIT, then port 1 wins.
REQ-029 Starve counter (4 bits): increments each IDLE arbitration port 1 requests and loses; clears when port 1 granted or I_req[1] = 0; saturates at STARVE_LIMIT.
REQ-030 O_gnt, O_rvalid, O_err never have more than one bit set; O_rf_enable = 0 outside ISSUE.
REQ-031 O_rA_data/O_rB_data = 0 outside RESP.

Reset
REQ-032 I_reset_n low asynchronously forces state INIT, all outputs 0 except O_rf_reset = 1, command registers 0, round-robin pointer = port 1, starve counter 0.
REQ-033 Reset during ISSUE or RESP aborts the access: no O_rvalid or O_err for it; a write not yet clocked by the register file is lost.
REQ-034 After I_reset_n rises, O_rf_reset stays 1 for one cycle (INIT) before any grant.

Verification
REQ-035 Reset release, port 0 writes r3 = 0xBEEF full word, then reads rA = r3 -> O_gnt = 01 at k+1, O_rvalid = 01 at k+2 with O_rA_data = 0xBEEF.
REQ-036 r5 = 0x1234; port 1 writes 0xAB00 wpos = 2, then 0x00CD wpos = 1 -> read r5 = 0xABCD.
REQ-037 ARB_MODE 1, both ports request continuously -> grants alternate 01, 10, 01, 10, first grant to port 0.
REQ-038 ARB_MODE 0, STARVE_LIMIT 4, both request continuously -> four port-0 grants, then one port-1 grant, repeat.
REQ-039 Port 0 write with wpos = 3 to r2 -> O_err = 01 in ISSUE, O_rf_write = 0, later read r2 unchanged.
REQ-040 I_reset_n pulsed low during ISSUE of write r7 = 0x5555 -> no O_rvalid, INIT one cycle, read r7 = 0x0000.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Two-port arbiter in front of a register file with registered read outputs.
// One access in flight: INIT -> IDLE -> ISSUE -> RESP -> IDLE.
module regfile_arbiter #(
  parameter int ARB_MODE     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic [1:0]  I_req,
  input  logic [1:0]  I_we,
  input  logic [2:0]  I_rA_sel0,
  input  logic [2:0]  I_rB_sel0,
  input  logic [2:0]  I_rD_sel0,
  input  logic [2:0]  I_rA_sel1,
  input  logic [2:0]  I_rB_sel1,
  input  logic [2:0]  I_rD_sel1,
  input  logic [15:0] I_wdata0,
  input  logic [15:0] I_wdata1,
  input  logic [1:0]  I_wpos0,
  input  logic [1:0]  I_wpos1,
  output logic [1:0]  O_gnt,
  output logic [1:0]  O_rvalid,
  output logic [15:0] O_rA_data,
  output logic [15:0] O_rB_data,
  output logic [1:0]  O_err,
  output logic        O_rf_reset,
  output logic        O_rf_enable,
  output logic        O_rf_write,
  output logic [2:0]  O_rf_rA_sel,
  output logic [2:0]  O_rf_rB_sel,
  output logic [2:0]  O_rf_rD_sel,
  output logic [15:0] O_rf_wdata,
  output logic [1:0]  O_rf_wpos,
  input  logic [15:0] I_rf_rA_out,
  input  logic [15:0] I_rf_rB_out
);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        win;
  logic        win_q, win_d;
  logic        rr_q, rr_d;
  logic [3:0]  starve_q, starve_d;
  logic [2:0]  ra_q, ra_d;
  logic [2:0]  rb_q, rb_d;
  logic [2:0]  rd_q, rd_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  wpos_q, wpos_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [1:0]  err_q, err_d;
  logic        rf_reset_q, rf_reset_d;
  logic        en_q, en_d;
  logic        wr_q, wr_d;

  logic [2:0]  s_ra, s_rb, s_rd;
  logic [15:0] s_wdata;
  logic [1:0]  s_wpos;
  logic        s_we;
  logic [1:0]  s_oh;

  always_comb begin
    win = 1'b0;
    if (I_req == 2'b10) begin
      win = 1'b1;
    end else if (I_req == 2'b11) begin
      if (ARB_MODE == 0) win = (starve_q == LIMIT);
      else               win = ~rr_q;
    end
  end

  always_comb begin
    s_ra    = win ? I_rA_sel1 : I_rA_sel0;
    s_rb    = win ? I_rB_sel1 : I_rB_sel0;
    s_rd    = win ? I_rD_sel1 : I_rD_sel0;
    s_wdata = win ? I_wdata1  : I_wdata0;
    s_wpos  = win ? I_wpos1   : I_wpos0;
    s_we    = I_we[win];
    s_oh    = win ? 2'b10 : 2'b01;
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    rr_d       = rr_q;
    starve_d   = I_req[1] ? starve_q : 4'd0;
    ra_d       = ra_q;
    rb_d       = rb_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    wpos_d     = wpos_q;
    gnt_d      = 2'b00;
    rvalid_d   = 2'b00;
    err_d      = 2'b00;
    rf_reset_d = 1'b0;
    en_d       = 1'b0;
    wr_d       = 1'b0;
    unique case (state_q)
      INIT: state_d = IDLE;
      IDLE: begin
        if (|I_req) begin
          state_d = ISSUE;
          win_d   = win;
          rr_d    = win;
          ra_d    = s_ra;
          rb_d    = s_rb;
          rd_d    = s_rd;
          wdata_d = s_wdata;
          wpos_d  = s_wpos;
          gnt_d   = s_oh;
          en_d    = 1'b1;
          wr_d    = s_we && (s_wpos != 2'd3);
          err_d   = (s_wpos == 2'd3) ? s_oh : 2'b00;
          // port 1 losing a contended round ages toward a forced grant
          if (win)
            starve_d = 4'd0;
          else if (I_req[1])
            starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
        end
      end
      ISSUE: begin
        state_d  = RESP;
        rvalid_d = win_q ? 2'b10 : 2'b01;
      end
      RESP: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q    <= INIT;
      win_q      <= 1'b0;
      rr_q       <= 1'b1;
      starve_q   <= 4'd0;
      ra_q       <= 3'd0;
      rb_q       <= 3'd0;
      rd_q       <= 3'd0;
      wdata_q    <= 16'd0;
      wpos_q     <= 2'd0;
      gnt_q      <= 2'b00;
      rvalid_q   <= 2'b00;
      err_q      <= 2'b00;
      rf_reset_q <= 1'b1;
      en_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      rr_q       <= rr_d;
      starve_q   <= starve_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      wpos_q     <= wpos_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rf_reset_q <= rf_reset_d;
      en_q       <= en_d;
      wr_q       <= wr_d;
    end
  end

  assign O_gnt       = gnt_q;
  assign O_rvalid    = rvalid_q;
  assign O_err       = err_q;
  assign O_rf_reset  = rf_reset_q;
  assign O_rf_enable = en_q;
  assign O_rf_write  = wr_q;
  assign O_rf_rA_sel = ra_q;
  assign O_rf_rB_sel = rb_q;
  assign O_rf_rD_sel = rd_q;
  assign O_rf_wdata  = wdata_q;
  assign O_rf_wpos   = wpos_q;
  // register file output is only meaningful the cycle after its enable
  assign O_rA_data   = (state_q == RESP) ? I_rf_rA_out : 16'd0;
  assign O_rB_data   = (state_q == RESP) ? I_rf_rB_out : 16'd0;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: round-robin and fixed-priority instances,
// each with a register file model and a transaction-level reference.
module tb_regfile_arbiter;

  localparam int LIM = 4;

  typedef struct packed {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [2:0]  ra0, rb0, rd0;
    logic [2:0]  ra1, rb1, rd1;
    logic [15:0] wd0, wd1;
    logic [1:0]  wp0, wp1;
  } drv_t;

  logic clk;
  logic rst_n;
  drv_t drv [2];

  logic [1:0]  gnt_w [2];
  logic [1:0]  rv_w [2];
  logic [1:0]  err_w [2];
  logic [15:0] rad_w [2];
  logic [15:0] rbd_w [2];
  logic        rfrst_w [2];
  logic        rfen_w [2];
  logic        rfwr_w [2];
  logic [2:0]  rasel_w [2];
  logic [2:0]  rbsel_w [2];
  logic [2:0]  rdsel_w [2];
  logic [15:0] wd_w [2];
  logic [1:0]  wpos_w [2];

  int total = 0;
  int bad = 0;
  logic [1:0] seq [12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t",
               nm, g, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int MODE = (g == 0) ? 1 : 0;

    logic [15:0] rfa, rfb;
    logic [15:0] mem [8];

    regfile_arbiter #(
      .ARB_MODE(MODE),
      .STARVE_LIMIT(LIM)
    ) u_dut (
      .I_clk(clk),
      .I_reset_n(rst_n),
      .I_req(drv[g].req),
      .I_we(drv[g].we),
      .I_rA_sel0(drv[g].ra0),
      .I_rB_sel0(drv[g].rb0),
      .I_rD_sel0(drv[g].rd0),
      .I_rA_sel1(drv[g].ra1),
      .I_rB_sel1(drv[g].rb1),
      .I_rD_sel1(drv[g].rd1),
      .I_wdata0(drv[g].wd0),
      .I_wdata1(drv[g].wd1),
      .I_wpos0(drv[g].wp0),
      .I_wpos1(drv[g].wp1),
      .O_gnt(gnt_w[g]),
      .O_rvalid(rv_w[g]),
      .O_rA_data(rad_w[g]),
      .O_rB_data(rbd_w[g]),
      .O_err(err_w[g]),
      .O_rf_reset(rfrst_w[g]),
      .O_rf_enable(rfen_w[g]),
      .O_rf_write(rfwr_w[g]),
      .O_rf_rA_sel(rasel_w[g]),
      .O_rf_rB_sel(rbsel_w[g]),
      .O_rf_rD_sel(rdsel_w[g]),
      .O_rf_wdata(wd_w[g]),
      .O_rf_wpos(wpos_w[g]),
      .I_rf_rA_out(rfa),
      .I_rf_rB_out(rfb)
    );

    // register file: sync reset, registered reads, byte-lane writes
    always @(posedge clk) begin
      if (rfrst_w[g] === 1'b1) begin
        for (int i = 0; i < 8; i++) mem[i] <= 16'd0;
        rfa <= 16'd0;
        rfb <= 16'd0;
      end else if (rfen_w[g] === 1'b1) begin
        rfa <= mem[rasel_w[g]];
        rfb <= mem[rbsel_w[g]];
        if (rfwr_w[g]) begin
          case (wpos_w[g])
            2'd0: mem[rdsel_w[g]] <= wd_w[g];
            2'd1: mem[rdsel_w[g]] <= {mem[rdsel_w[g]][15:8], wd_w[g][7:0]};
            2'd2: mem[rdsel_w[g]] <= {wd_w[g][15:8], mem[rdsel_w[g]][7:0]};
            default: ;
          endcase
        end
      end
    end

    // reference: expectations keyed by cycle number
    int cyc = 0;
    int hold = 0;
    int last = 1;
    int starve = 0;
    bit in_init = 1'b1;
    bit pw = 1'b0;
    int pw_cyc = 0;
    logic [2:0]  pw_rd;
    logic [15:0] pw_d;
    logic [1:0]  pw_pos;
    logic [15:0] sh [8];
    logic [1:0]  e_gnt [int];
    logic [1:0]  e_err [int];
    logic [1:0]  e_rv [int];
    logic        e_wr [int];
    logic [15:0] e_a [int];
    logic [15:0] e_b [int];
    logic [26:0] e_cmd [int];

    always @(posedge clk or negedge rst_n) begin
      int p;
      logic [2:0] ra, rb, rd;
      logic [15:0] wd;
      logic [1:0] wp;
      logic we;
      if (!rst_n) begin
        e_gnt.delete(); e_err.delete(); e_rv.delete(); e_wr.delete();
        e_a.delete(); e_b.delete(); e_cmd.delete();
        in_init = 1'b1;
        pw = 1'b0;
        hold = 0;
        last = 1;
        starve = 0;
        for (int i = 0; i < 8; i++) sh[i] = 16'd0;
      end else begin
        cyc++;
        if (!drv[g].req[1]) starve = 0;
        if (pw && cyc == pw_cyc) begin
          case (pw_pos)
            2'd0: sh[pw_rd] = pw_d;
            2'd1: sh[pw_rd][7:0] = pw_d[7:0];
            default: sh[pw_rd][15:8] = pw_d[15:8];
          endcase
          pw = 1'b0;
        end
        if (in_init) begin
          in_init = 1'b0;
        end else if (hold > 0) begin
          hold--;
        end else if (drv[g].req != 2'b00) begin
          if (drv[g].req != 2'b11) p = drv[g].req[1] ? 1 : 0;
          else if (MODE == 1) p = 1 - last;
          else p = (starve == LIM) ? 1 : 0;
          last = p;
          if (p == 1) starve = 0;
          else if (drv[g].req[1]) starve = (starve < LIM) ? starve + 1 : LIM;
          ra = (p == 1) ? drv[g].ra1 : drv[g].ra0;
          rb = (p == 1) ? drv[g].rb1 : drv[g].rb0;
          rd = (p == 1) ? drv[g].rd1 : drv[g].rd0;
          wd = (p == 1) ? drv[g].wd1 : drv[g].wd0;
          wp = (p == 1) ? drv[g].wp1 : drv[g].wp0;
          we = drv[g].we[p];
          e_gnt[cyc] = (p == 1) ? 2'b10 : 2'b01;
          e_err[cyc] = (wp == 2'd3) ? e_gnt[cyc] : 2'b00;
          e_wr[cyc] = we && (wp != 2'd3);
          e_cmd[cyc] = {ra, rb, rd, wd, wp};
          e_rv[cyc + 1] = e_gnt[cyc];
          e_a[cyc + 1] = sh[ra];
          e_b[cyc + 1] = sh[rb];
          if (we && wp != 2'd3) begin
            pw = 1'b1;
            pw_cyc = cyc + 1;
            pw_rd = rd;
            pw_d = wd;
            pw_pos = wp;
          end
          hold = 2;
        end
      end
    end

    always @(negedge clk) begin
      logic [1:0] eg, ee, ev;
      logic ew;
      logic [15:0] ea, eb;
      eg = e_gnt.exists(cyc) ? e_gnt[cyc] : 2'b00;
      ee = e_err.exists(cyc) ? e_err[cyc] : 2'b00;
      ev = e_rv.exists(cyc) ? e_rv[cyc] : 2'b00;
      ew = e_wr.exists(cyc) ? e_wr[cyc] : 1'b0;
      ea = e_a.exists(cyc) ? e_a[cyc] : 16'd0;
      eb = e_b.exists(cyc) ? e_b[cyc] : 16'd0;
      chk("gnt", g, 32'(gnt_w[g]), 32'(eg));
      chk("rvalid", g, 32'(rv_w[g]), 32'(ev));
      chk("err", g, 32'(err_w[g]), 32'(ee));
      chk("rf_reset", g, 32'(rfrst_w[g]), 32'(in_init));
      chk("rf_enable", g, 32'(rfen_w[g]), 32'(eg != 2'b00));
      chk("rf_write", g, 32'(rfwr_w[g]), 32'(ew));
      chk("rA_data", g, 32'(rad_w[g]), 32'(ea));
      chk("rB_data", g, 32'(rbd_w[g]), 32'(eb));
      if (eg != 2'b00)
        chk("rf_cmd", g,
            32'({rasel_w[g], rbsel_w[g], rdsel_w[g], wd_w[g], wpos_w[g]}),
            32'(e_cmd[cyc]));
    end
  end

  task automatic set_pl(input int g, input int p, input logic we,
                        input logic [2:0] ra, input logic [2:0] rb,
                        input logic [2:0] rd, input logic [15:0] wd,
                        input logic [1:0] wp);
    drv[g].we[p] = we;
    if (p == 0) begin
      drv[g].ra0 = ra; drv[g].rb0 = rb; drv[g].rd0 = rd;
      drv[g].wd0 = wd; drv[g].wp0 = wp;
    end else begin
      drv[g].ra1 = ra; drv[g].rb1 = rb; drv[g].rd1 = rd;
      drv[g].wd1 = wd; drv[g].wp1 = wp;
    end
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    #1 rst_n = 1'b0;
    drv[0].req = 2'b00;
    drv[1].req = 2'b00;
    repeat (2) @(negedge clk);
    release_rst();
  endtask

  task automatic acc(input int g, input int p, input logic we,
                     input logic [2:0] ra, input logic [2:0] rb,
                     input logic [2:0] rd, input logic [15:0] wd,
                     input logic [1:0] wp, output logic [15:0] da,
                     output int lat, output int rlat,
                     output logic [1:0] ev, output logic wr);
    bit got;
    set_pl(g, p, we, ra, rb, rd, wd, wp);
    drv[g].req[p] = 1'b1;
    lat = 0; rlat = 0; da = 16'd0; ev = 2'b00; wr = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (gnt_w[g][p]) begin
        got = 1'b1;
        ev = err_w[g];
        wr = rfwr_w[g];
      end
    end
    #1 drv[g].req[p] = 1'b0;
    chk("gnt_seen", g, 32'(got), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      rlat++;
      if (rv_w[g][p]) begin
        got = 1'b1;
        da = rad_w[g];
      end
    end
    #1;
    chk("rvalid_seen", g, 32'(got), 32'd1);
  endtask

  task automatic both_run(input int g, input int n);
    int k;
    set_pl(g, 0, 1'b0, 3'd1, 3'd2, 3'd0, 16'd0, 2'd0);
    set_pl(g, 1, 1'b0, 3'd3, 3'd4, 3'd0, 16'd0, 2'd0);
    drv[g].req = 2'b11;
    k = 0;
    for (int i = 0; i < 80 && k < n; i++) begin
      @(negedge clk);
      if (gnt_w[g] != 2'b00) begin
        seq[k] = gnt_w[g];
        k++;
      end
    end
    #1 drv[g].req = 2'b00;
    chk("grant_count", g, 32'(k), 32'(n));
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic rand_pl(input int g, input int p);
    logic [1:0] wp;
    wp = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    set_pl(g, p, 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
           16'($urandom), wp);
  endtask

  task automatic rand_run(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (i == n / 2) begin
        rst_n = 1'b0;
        drv[g].req = 2'b00;
        repeat (2) @(negedge clk);
        release_rst();
      end
      for (int p = 0; p < 2; p++) begin
        if (gnt_w[g][p]) begin
          drv[g].req[p] = 1'b0;
          if ($urandom_range(0, 1) == 1) begin
            rand_pl(g, p);
            drv[g].req[p] = 1'b1;
          end
        end else if (drv[g].req[p]) begin
          if ($urandom_range(0, 15) == 0) drv[g].req[p] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          rand_pl(g, p);
          drv[g].req[p] = 1'b1;
        end
      end
    end
    drv[g].req = 2'b00;
    repeat (4) @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] da;
    int lat, rlat;
    logic [1:0] ev;
    logic wr;
    bit rvs;
    drv[0] = '0;
    drv[1] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rf_reset", 0, 32'(rfrst_w[0]), 32'd1);
    chk("reset_gnt", 1, 32'(gnt_w[1]), 32'd0);
    release_rst();

    // write r3 then read it back, latency from an idle arbiter
    acc(0, 0, 1'b1, 3'd0, 3'd0, 3'd3, 16'hBEEF, 2'd0, da, lat, rlat, ev, wr);
    chk("idle_gnt_latency", 0, 32'(lat), 32'd1);
    chk("rvalid_latency", 0, 32'(rlat), 32'd1);
    chk("write_strobe", 0, 32'(wr), 32'd1);
    acc(0, 0, 1'b0, 3'd3, 3'd0, 3'd0, 16'd0, 2'd0, da, lat, rlat, ev, wr);
    chk("r3_readback", 0, 32'(da), 32'hBEEF);

    // byte-lane merge from port 1
    acc(0, 0, 1'b1, 3'd0, 3'd0, 3'd5, 16'h1234, 2'd0, da, lat, rlat, ev, wr);
    acc(0, 1, 1'b1, 3'd5, 3'd0, 3'd5, 16'hAB00, 2'd2, da, lat, rlat, ev, wr);
    chk("pre_write_read", 0, 32'(da), 32'h1234);
    acc(0, 1, 1'b1, 3'd0, 3'd0, 3'd5, 16'h00CD, 2'd1, da, lat, rlat, ev, wr);
    acc(0, 1, 1'b0, 3'd5, 3'd0, 3'd0, 16'd0, 2'd0, da, lat, rlat, ev, wr);
    chk("r5_bytes", 0, 32'(da), 32'hABCD);

    // illegal write position
    acc(0, 0, 1'b1, 3'd0, 3'd0, 3'd2, 16'h7777, 2'd0, da, lat, rlat, ev, wr);
    acc(0, 0, 1'b1, 3'd0, 3'd0, 3'd2, 16'h1111, 2'd3, da, lat, rlat, ev, wr);
    chk("wpos3_err", 0, 32'(ev), 32'd1);
    chk("wpos3_no_write", 0, 32'(wr), 32'd0);
    acc(0, 0, 1'b0, 3'd2, 3'd0, 3'd0, 16'd0, 2'd0, da, lat, rlat, ev, wr);
    chk("r2_unchanged", 0, 32'(da), 32'h7777);

    // reset during ISSUE of a write
    set_pl(0, 0, 1'b1, 3'd0, 3'd0, 3'd7, 16'h5555, 2'd0);
    drv[0].req[0] = 1'b1;
    for (int i = 0; i < 10 && gnt_w[0][0] !== 1'b1; i++) @(negedge clk);
    chk("abort_gnt_seen", 0, 32'(gnt_w[0]), 32'd1);
    #1 rst_n = 1'b0;
    drv[0].req = 2'b00;
    rvs = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rvs = rvs | (rv_w[0] != 2'b00);
    end
    chk("abort_no_rvalid", 0, 32'(rvs), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("init_rf_reset", 0, 32'(rfrst_w[0]), 32'd1);
    @(negedge clk);
    chk("idle_rf_reset", 0, 32'(rfrst_w[0]), 32'd0);
    #1;
    acc(0, 0, 1'b0, 3'd7, 3'd0, 3'd0, 16'd0, 2'd0, da, lat, rlat, ev, wr);
    chk("r7_lost", 0, 32'(da), 32'h0000);

    // round-robin alternation
    rst_pulse();
    both_run(0, 8);
    for (int i = 0; i < 8; i++)
      chk("rr_seq", 0, 32'(seq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

    // fixed priority with starvation relief
    rst_pulse();
    both_run(1, 10);
    for (int i = 0; i < 10; i++)
      chk("fp_seq", 1, 32'(seq[i]), (i % 5 == 4) ? 32'd2 : 32'd1);

    rst_pulse();
    rand_run(0, 1500);
    rst_pulse();
    rand_run(1, 1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
